// File: rtl/vx_tag_assoc_if.sv
// Request/response bundle for the vx_tag_assoc tag array.
// The master side drives lookup/fill/flush requests; the slave side (the tag
// array) returns ready and the registered lookup results.
interface vx_tag_assoc_if #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int NUM_WAYS        = 4
);
    logic                       i_stall;
    logic                       i_lookup;
    logic                       i_fill;
    logic                       i_flush;
    logic                       i_flush_all;
    logic [LINE_ADDR_WIDTH-1:0] i_addr;
    logic                       o_ready;
    logic                       o_tag_match;
    logic [NUM_WAYS-1:0]        o_hit_way;
    logic [NUM_WAYS-1:0]        o_victim_way;

    modport master (
        output i_stall, i_lookup, i_fill, i_flush, i_flush_all, i_addr,
        input  o_ready, o_tag_match, o_hit_way, o_victim_way
    );

    modport slave (
        input  i_stall, i_lookup, i_fill, i_flush, i_flush_all, i_addr,
        output o_ready, o_tag_match, o_hit_way, o_victim_way
    );
endinterface

// File: rtl/vx_tag_assoc.sv
// Set-associative tag array with round-robin replacement.
// Each set holds NUM_WAYS tags (not reset), a valid bit per way and a
// round-robin pointer. Lookups return hit/victim information one cycle later.
// A whole-array invalidate is done by an IDLE/SWEEP state machine that clears
// one set per unstalled cycle; requests are refused (ready low) meanwhile.
module vx_tag_assoc #(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int NUM_BANKS       = 1,
    parameter int NUM_WAYS        = 4,
    parameter int LINE_ADDR_WIDTH = 26
) (
    input  logic           i_clk,
    input  logic           i_rst,
    vx_tag_assoc_if.slave  bus
);
    localparam int SETS     = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS * NUM_WAYS);
    localparam int SET_BITS = $clog2(SETS);
    localparam int TAG_BITS = LINE_ADDR_WIDTH - SET_BITS;
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // One-hot of the lowest clear bit; zero when every way is valid.
    function automatic logic [NUM_WAYS-1:0] f_lowest_invalid(input logic [NUM_WAYS-1:0] valid);
        logic [NUM_WAYS-1:0] res;
        logic                found;
        res   = '0;
        found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid[w] && !found) begin
                res[w] = 1'b1;
                found  = 1'b1;
            end else begin
                res[w] = res[w];
            end
        end
        return res;
    endfunction

    // One-hot decode of a round-robin pointer.
    function automatic logic [NUM_WAYS-1:0] f_way_onehot(input logic [WAY_BITS-1:0] ptr);
        logic [NUM_WAYS-1:0] res;
        for (int w = 0; w < NUM_WAYS; w++) begin
            res[w] = (WAY_BITS'(w) == ptr);
        end
        return res;
    endfunction

    // Pointer advance modulo NUM_WAYS (NUM_WAYS is a power of two, so the
    // natural wrap of the WAY_BITS-wide add is the modulo; direct-mapped stays 0).
    function automatic logic [WAY_BITS-1:0] f_ptr_inc(input logic [WAY_BITS-1:0] ptr);
        if (NUM_WAYS == 1) begin
            return '0;
        end else begin
            return ptr + WAY_BITS'(1);
        end
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SET_BITS-1:0]   r_sweep_cnt;
    logic [NUM_WAYS-1:0]   r_valid [SETS];
    logic [WAY_BITS-1:0]   r_ptr   [SETS];
    logic [TAG_BITS-1:0]   r_tags  [SETS][NUM_WAYS];
    logic                  r_tag_match;
    logic [NUM_WAYS-1:0]   r_hit_way;
    logic [NUM_WAYS-1:0]   r_victim_way;

    logic [SET_BITS-1:0]   w_set;
    logic [TAG_BITS-1:0]   w_tag;
    logic [NUM_WAYS-1:0]   w_set_valid;
    logic [WAY_BITS-1:0]   w_set_ptr;
    logic [NUM_WAYS-1:0]   w_hit_vec;
    logic [NUM_WAYS-1:0]   w_lowest_inv;
    logic [NUM_WAYS-1:0]   w_victim;
    logic [NUM_WAYS-1:0]   w_fill_target;
    logic                  w_any_hit;
    logic                  w_fill_evicts;
    logic                  w_accept;
    logic                  w_do_lookup;
    logic                  w_do_fill;
    logic                  w_do_flush;
    logic                  w_start_sweep;
    logic                  w_sweep_step;
    logic                  w_sweep_last;

    assign w_set       = bus.i_addr[SET_BITS-1:0];
    assign w_tag       = bus.i_addr[LINE_ADDR_WIDTH-1:SET_BITS];
    assign w_set_valid = r_valid[w_set];
    assign w_set_ptr   = r_ptr[w_set];

    // Request qualification: nothing is accepted during a sweep or a stall;
    // a flush in the same cycle as a fill drops the fill.
    always_comb begin
        w_accept      = (r_state == ST_IDLE) && !bus.i_stall;
        w_do_lookup   = w_accept && bus.i_lookup;
        w_do_flush    = w_accept && bus.i_flush;
        w_do_fill     = w_accept && bus.i_fill && !bus.i_flush;
        w_start_sweep = w_accept && bus.i_flush_all;
        w_sweep_step  = (r_state == ST_SWEEP) && !bus.i_stall;
        w_sweep_last  = (r_sweep_cnt == LAST_SET);
    end

    // Tag compare and victim selection against the pre-update set contents.
    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_hit_vec[w] = w_set_valid[w] && (r_tags[w_set][w] == w_tag);
        end
        w_any_hit    = |w_hit_vec;
        w_lowest_inv = f_lowest_invalid(w_set_valid);
        if (w_lowest_inv != '0) begin
            w_victim = w_lowest_inv;
        end else begin
            w_victim = f_way_onehot(w_set_ptr);
        end
        // A resident tag is rewritten in place rather than duplicated.
        if (w_any_hit) begin
            w_fill_target = w_hit_vec;
        end else begin
            w_fill_target = w_victim;
        end
        w_fill_evicts = !w_any_hit && (&w_set_valid);
    end

    // Sweep state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (!bus.i_stall) begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep next-state: enter on flush_all, leave after the last set is cleared.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_sweep) begin
                    w_state_nxt = ST_SWEEP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (w_sweep_step && w_sweep_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sweep set counter; holds while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sweep_cnt <= '0;
        end else if (w_start_sweep) begin
            r_sweep_cnt <= '0;
        end else if (w_sweep_step) begin
            if (w_sweep_last) begin
                r_sweep_cnt <= '0;
            end else begin
                r_sweep_cnt <= r_sweep_cnt + SET_BITS'(1);
            end
        end
    end

    // Valid bits and round-robin pointers: sweep clear, set flush, or fill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (w_sweep_step) begin
            r_valid[r_sweep_cnt] <= '0;
            r_ptr[r_sweep_cnt]   <= '0;
        end else if (w_do_flush) begin
            r_valid[w_set] <= '0;
            r_ptr[w_set]   <= '0;
        end else if (w_do_fill) begin
            r_valid[w_set] <= w_set_valid | w_fill_target;
            if (w_fill_evicts) begin
                r_ptr[w_set] <= f_ptr_inc(w_set_ptr);
            end
        end
    end

    // Tag storage write on fill; contents are qualified by valid, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_fill) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w_fill_target[w]) begin
                    r_tags[w_set][w] <= w_tag;
                end
            end
        end
    end

    // Registered lookup results; hit indication is cleared when a sweep starts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag_match  <= 1'b0;
            r_hit_way    <= '0;
            r_victim_way <= '0;
        end else if (!bus.i_stall) begin
            if (w_do_lookup) begin
                r_tag_match  <= w_any_hit;
                r_hit_way    <= w_hit_vec;
                r_victim_way <= w_victim;
            end
            if (w_start_sweep) begin
                r_tag_match <= 1'b0;
                r_hit_way   <= '0;
            end
        end
    end

    assign bus.o_ready        = (r_state == ST_IDLE);
    assign bus.o_tag_match    = r_tag_match;
    assign bus.o_hit_way      = r_hit_way;
    assign bus.o_victim_way   = r_victim_way;

endmodule

// File: tb/tb_vx_tag_assoc.sv
// Self-checking bench for vx_tag_assoc: directed scenarios followed by random
// traffic, every cycle compared against an array-based reference model.
module tb_vx_tag_assoc;
    localparam int LAW  = 26;
    localparam int W    = 4;
    localparam int SETS = 16384 / (64 * 1 * W);

    logic clk;
    logic rst;

    vx_tag_assoc_if #(.LINE_ADDR_WIDTH(LAW), .NUM_WAYS(W)) bus ();

    vx_tag_assoc #(
        .CACHE_SIZE(16384), .CACHE_LINE_SIZE(64), .NUM_BANKS(1),
        .NUM_WAYS(W), .LINE_ADDR_WIDTH(LAW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_tag   [SETS][W];
    bit m_valid [SETS][W];
    int m_ptr   [SETS];
    bit m_sweep;
    int m_cnt;
    bit m_match;
    int m_hit;
    int m_vic;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mk(input int tag, input int set);
        return tag * SETS + set;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < W; w++) m_valid[s][w] = 1'b0;
        end
        m_sweep = 1'b0;
        m_cnt   = 0;
        m_match = 1'b0;
        m_hit   = 0;
        m_vic   = 0;
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        int a, set, tag, hit, vic;
        bit all_valid;
        if (bus.i_stall) return;
        if (m_sweep) begin
            for (int w = 0; w < W; w++) m_valid[m_cnt][w] = 1'b0;
            m_ptr[m_cnt] = 0;
            if (m_cnt == SETS - 1) m_sweep = 1'b0;
            else m_cnt++;
            return;
        end
        a   = int'(bus.i_addr);
        set = a % SETS;
        tag = a / SETS;
        hit = -1;
        vic = -1;
        all_valid = 1'b1;
        for (int w = 0; w < W; w++) begin
            if (m_valid[set][w] && m_tag[set][w] == tag) hit = w;
            if (!m_valid[set][w]) begin
                all_valid = 1'b0;
                if (vic < 0) vic = w;
            end
        end
        if (vic < 0) vic = m_ptr[set];
        if (bus.i_lookup) begin
            m_match = (hit >= 0);
            m_hit   = (hit >= 0) ? (1 << hit) : 0;
            m_vic   = 1 << vic;
        end
        if (bus.i_flush_all) begin
            m_match = 1'b0;
            m_hit   = 0;
            m_sweep = 1'b1;
            m_cnt   = 0;
        end
        if (bus.i_flush) begin
            for (int w = 0; w < W; w++) m_valid[set][w] = 1'b0;
            m_ptr[set] = 0;
        end else if (bus.i_fill) begin
            if (hit >= 0) begin
                m_tag[set][hit] = tag;
            end else begin
                if (all_valid) m_ptr[set] = (m_ptr[set] + 1) % W;
                m_tag[set][vic]   = tag;
                m_valid[set][vic] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("ready",      32'(bus.o_ready),      32'(!m_sweep));
        check("tag_match",  32'(bus.o_tag_match),  32'(m_match));
        check("hit_way",    32'(bus.o_hit_way),    32'(m_hit));
        check("victim_way", 32'(bus.o_victim_way), 32'(m_vic));
    endtask

    task automatic cycle(input bit st, input bit lk, input bit fl, input bit fs,
                         input bit fa, input int a);
        bus.i_stall     = st;
        bus.i_lookup    = lk;
        bus.i_fill      = fl;
        bus.i_flush     = fs;
        bus.i_flush_all = fa;
        bus.i_addr      = LAW'(a);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic lookup(input int a);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic fill(input int a);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("ready_in_reset", 32'(bus.o_ready), 32'd1);
        check_outputs();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lows;
        bit st;
        n_vec = 0;
        n_err = 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < W; w++) m_tag[s][w] = 0;
        bus.i_stall = 1'b0; bus.i_lookup = 1'b0; bus.i_fill = 1'b0;
        bus.i_flush = 1'b0; bus.i_flush_all = 1'b0; bus.i_addr = '0;
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        #1;
        rst = 1'b0;

        // Lookup right after reset: miss, victim is way 0
        lookup(32'h40);
        check("r037_match",  32'(bus.o_tag_match),  32'd0);
        check("r037_victim", 32'(bus.o_victim_way), 32'h1);

        // Four fills into set 5, then a fifth that evicts way 0
        for (int t = 1; t <= 4; t++) fill(mk(t, 5));
        lookup(mk(3, 5));
        check("r038_match", 32'(bus.o_tag_match), 32'd1);
        check("r038_hit",   32'(bus.o_hit_way),   32'h4);
        fill(mk(5, 5));
        lookup(mk(1, 5));
        check("r038_evicted", 32'(bus.o_tag_match),  32'd0);
        check("r038_ptr1",    32'(bus.o_victim_way), 32'h2);
        lookup(mk(5, 5));
        check("r038_newhit", 32'(bus.o_hit_way), 32'h1);
        fill(mk(3, 5));
        lookup(mk(3, 5));
        check("r025_rewrite", 32'(bus.o_victim_way), 32'h2);

        // Fill and lookup in the same cycle see the old contents
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(9, 7));
        check("r039_same", 32'(bus.o_tag_match), 32'd0);
        lookup(mk(9, 7));
        check("r039_next", 32'(bus.o_tag_match), 32'd1);

        // Fill and flush together: flush wins
        fill(mk(2, 3));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(4, 3));
        lookup(mk(2, 3));
        check("r040_old", 32'(bus.o_tag_match), 32'd0);
        lookup(mk(4, 3));
        check("r040_new",    32'(bus.o_tag_match),  32'd0);
        check("r040_victim", 32'(bus.o_victim_way), 32'h1);

        // Sweep with a three-cycle stall in the middle
        fill(mk(6, 10));
        fill(mk(7, 63));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        lows = bus.o_ready ? 0 : 1;
        for (int k = 0; k < 200 && !bus.o_ready; k++) begin
            st = (k >= 20 && k < 23);
            cycle(st, 1'b1, 1'b1, 1'b0, k == 30, mk(1, 1));
            if (!bus.o_ready) lows++;
        end
        check("r041_ready_low", 32'(lows), 32'd67);
        lookup(mk(6, 10));
        check("r041_miss_a", 32'(bus.o_tag_match), 32'd0);
        lookup(mk(7, 63));
        check("r041_miss_b", 32'(bus.o_tag_match), 32'd0);
        lookup(mk(5, 5));
        check("r041_miss_c", 32'(bus.o_tag_match), 32'd0);

        // Reset in the middle of a sweep
        fill(mk(8, 20));
        fill(mk(9, 20));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 10; k++) idle();
        check("r042_in_sweep", 32'(bus.o_ready), 32'd0);
        do_reset();
        lookup(mk(8, 20));
        check("r042_miss", 32'(bus.o_tag_match), 32'd0);
        check("r042_vic",  32'(bus.o_victim_way), 32'h1);

        // Random traffic over a small tag/set pool to force hits and evictions
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 10) == 0, ($urandom % 2) == 0, ($urandom % 3) == 0,
                  ($urandom % 25) == 0, ($urandom % 300) == 0,
                  mk($urandom_range(0, 6), $urandom_range(0, 3)));
        end
        while (m_sweep) idle();
        for (int s = 0; s < 4; s++)
            for (int t = 0; t <= 6; t++) lookup(mk(t, s));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vx_tag_assoc.md
VX_TAG_ASSOC -- requirements
Module: VX_tag_assoc

Interface
REQ-001 SHALL: CACHE_SIZE, default 16384, total cache bytes.
REQ-002 SHALL: CACHE_LINE_SIZE, default 64, line bytes.
REQ-003 SHALL: NUM_BANKS, default 1, bank count.
REQ-004 SHALL: NUM_WAYS, default 4, associativity, power of 2, 1..16.
REQ-005 SHALL: LINE_ADDR_WIDTH, default 26, line address width.
REQ-006 SHALL: derived SETS = CACHE_SIZE/(CACHE_LINE_SIZE*NUM_BANKS*NUM_WAYS), SET_BITS = log2(SETS), TAG_BITS = LINE_ADDR_WIDTH-SET_BITS.
REQ-007 SHALL: clk  in  1  clock, all state on rising edge.
REQ-008 SHALL: reset  in  1  one clock; reset is asynchronous and active-high.
REQ-009 SHALL: stall  in  1  freezes all state and outputs.
REQ-010 SHALL: lookup  in  1  tag lookup request.
REQ-011 SHALL: fill  in  1  install addr tag into chosen victim way.
REQ-012 SHALL: flush  in  1  invalidate all ways of addressed set.
REQ-013 SHALL: flush_all  in  1  start whole-array invalidate sweep.
REQ-014 SHALL: addr  in  LINE_ADDR_WIDTH  set = addr[SET_BITS-1:0], tag = upper TAG_BITS.
REQ-015 SHALL: ready  out  1  high when no sweep active.
REQ-016 SHALL: tag_match  out  1  registered hit result.
REQ-017 SHALL: hit_way  out  NUM_WAYS  registered one-hot hit way, zero on miss.
REQ-018 SHALL: victim_way  out  NUM_WAYS  registered one-hot way a fill to that set would use.

Function
REQ-019 SHALL: per set, per way: tag store (not reset), valid bit and one log2(NUM_WAYS)-bit round-robin pointer per set (flops, async reset).
REQ-020 SHALL: accepted op = ready & ~stall; lookup/fill/flush ignored otherwise.
REQ-021 SHALL: lookup accepted at edge N -> tag_match/hit_way/victim_way valid after edge N+1 (one-cycle latency), held until next accepted lookup or stall release.
REQ-022 SHALL: hit = way valid & stored tag == addr tag; at most one way hits (fill never duplicates a tag).
REQ-023 SHALL: victim = lowest-index invalid way if any, else way at set pointer.
REQ-024 SHALL: fill writes tag into victim, sets its valid; pointer increments modulo NUM_WAYS only when a valid way was replaced.
REQ-025 SHALL: fill of a tag already resident in the set rewrites the hitting way, no pointer change.
REQ-026 SHALL: flush clears all valid bits of the set and resets its pointer to 0.
REQ-027 SHALL: lookup same cycle as fill/flush to same set returns pre-update state.
REQ-028 SHALL: fill and flush same cycle: flush wins, fill dropped.
REQ-029 SHALL: FSM IDLE/SWEEP; flush_all & ~stall in IDLE -> SWEEP, set counter 0.
REQ-030 SHALL: SWEEP clears set[counter] per non-stalled cycle; after set SETS-1 -> IDLE; duration exactly SETS unstalled cycles.
REQ-031 SHALL: ready = (state==IDLE); tag_match and hit_way forced 0 while SWEEP.
REQ-032 SHALL: flush_all in SWEEP ignored; stall in SWEEP pauses counter.
REQ-033 SHALL: NUM_WAYS=1 degenerates to direct-mapped, victim_way constant 1.

Reset
REQ-034 SHALL: reset asserted asynchronously clears all valid bits, pointers, sweep counter, tag_match, hit_way, victim_way to 0, FSM to IDLE.
REQ-035 SHALL: ready = 1 from reset assertion onward; ops accepted first edge after deassertion.
REQ-036 SHALL: reset mid-sweep aborts sweep; no partial state survives.

Verification
REQ-037 SHALL: defaults; after reset lookup addr 0x40 -> tag_match 0, hit_way 0, victim_way 0b0001.
REQ-038 SHALL: fill 4 tags into set 5, lookup third -> tag_match 1, hit_way 0b0100; fifth fill evicts way 0, pointer 1.
REQ-039 SHALL: fill+lookup same set same cycle -> lookup misses; next-cycle lookup hits.
REQ-040 SHALL: fill+flush same cycle set 3 -> all set-3 lookups miss, victim_way 0b0001.
REQ-041 SHALL: flush_all -> ready low exactly 64 cycles (defaults), stall 3 cycles mid-sweep extends to 67, then all lookups miss.
REQ-042 SHALL: reset at sweep cycle 10 -> ready 1 immediately, state IDLE, all valids 0.
